// File: rtl/pipe_pkg.sv
// Shared miniRV pipeline constants: datapath width, PC step, reset PC and NOP encoding.
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC       = 32'd4;
    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_HOLD,
        PC_SEL_REDIRECT
    } pc_sel_e;

    // Instruction fetch is word-aligned; low address bits of a target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/reg_if_id.sv
// IF/ID pipeline register with flush (priority) and stall (hold).
// IF_TRACE_EN adds the have_inst_o valid flag and clears pc_o/pc4_o on flush.
module reg_if_id
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o
`ifdef IF_TRACE_EN
    ,
    output logic            have_inst_o
`endif
);

    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q,   pc_d;
    logic [XLEN-1:0] pc4_q,  pc4_d;
`ifdef IF_TRACE_EN
    logic            have_q, have_d;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        inst_d = inst_q;
        pc_d   = pc_q;
        pc4_d  = pc4_q;
`ifdef IF_TRACE_EN
        have_d = have_q;
`endif
        if (flush) begin
            inst_d = NOP_INST;
`ifdef IF_TRACE_EN
            pc_d   = '0;
            pc4_d  = '0;
            have_d = 1'b0;
`endif
        end else if (!stall) begin
            inst_d = inst_i;
            pc_d   = pc_i;
            pc4_d  = pc4_i;
`ifdef IF_TRACE_EN
            have_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (rst) begin
            inst_q <= NOP_INST;
            pc_q   <= '0;
            pc4_q  <= '0;
`ifdef IF_TRACE_EN
            have_q <= 1'b0;
`endif
        end else begin
            inst_q <= inst_d;
            pc_q   <= pc_d;
            pc4_q  <= pc4_d;
`ifdef IF_TRACE_EN
            have_q <= have_d;
`endif
        end
    end

    assign inst_o = inst_q;
    assign pc_o   = pc_q;
    assign pc4_o  = pc4_q;
`ifdef IF_TRACE_EN
    assign have_inst_o = have_q;
`endif

endmodule

// File: rtl/if_stage.sv
// miniRV instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// IF_TRACE_EN exposes have_inst_o for the trace harness.
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] irom_addr,
    input  logic [XLEN-1:0] irom_inst,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o
`ifdef IF_TRACE_EN
    ,
    output logic            have_inst_o
`endif
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    pc_sel_e         pc_sel;

    assign pc_plus4 = pc_q + PC_INC;

    // Redirect outranks stall: a stalled instruction on the wrong path is dropped.
    always_comb begin
        if (redirect)   pc_sel = PC_SEL_REDIRECT;
        else if (stall) pc_sel = PC_SEL_HOLD;
        else            pc_sel = PC_SEL_SEQ;
    end

    always_comb begin
        pc_d = pc_plus4;
        case (pc_sel)
            PC_SEL_REDIRECT: pc_d = align_pc(redirect_pc);
            PC_SEL_HOLD:     pc_d = pc_q;
            default:         pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign irom_addr = pc_q;

    reg_if_id #(
        .NOP_INST (NOP_INST)
    ) u_reg_if_id (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (redirect),
        .inst_i      (irom_inst),
        .pc_i        (pc_q),
        .pc4_i       (pc_plus4),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .pc4_o       (pc4_o)
`ifdef IF_TRACE_EN
        ,
        .have_inst_o (have_inst_o)
`endif
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; the ROM returns its own address as data.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] irom_addr;
    logic [31:0] irom_inst;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
`ifdef IF_TRACE_EN
    logic        have_inst_o;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irom_addr   (irom_addr),
        .irom_inst   (irom_inst),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .pc4_o       (pc4_o)
`ifdef IF_TRACE_EN
        ,
        .have_inst_o (have_inst_o)
`endif
    );

    always #5 clk = ~clk;

    assign irom_inst = irom_addr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks irom_addr and the whole IF/ID register against expected values.
    task automatic expect_state(input string tag, input logic [31:0] e_addr,
                                input logic [31:0] e_inst, input logic [31:0] e_pc,
                                input logic [31:0] e_pc4, input logic e_have);
        total++;
        if (irom_addr !== e_addr) begin
            bad++; $display("FAIL %s irom_addr got=%h exp=%h", tag, irom_addr, e_addr);
        end
        total++;
        if (inst_o !== e_inst) begin
            bad++; $display("FAIL %s inst_o got=%h exp=%h", tag, inst_o, e_inst);
        end
        total++;
        if (pc_o !== e_pc) begin
            bad++; $display("FAIL %s pc_o got=%h exp=%h", tag, pc_o, e_pc);
        end
        total++;
        if (pc4_o !== e_pc4) begin
            bad++; $display("FAIL %s pc4_o got=%h exp=%h", tag, pc4_o, e_pc4);
        end
`ifdef IF_TRACE_EN
        total++;
        if (have_inst_o !== e_have) begin
            bad++; $display("FAIL %s have_inst_o got=%b exp=%b", tag, have_inst_o, e_have);
        end
`else
        if (e_have === 1'bx) $display("note: %s", tag);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        step();
        expect_state("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        expect_state("reset_release", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_free_run();
        step(); expect_state("run1", 32'h4,  32'h0, 32'h0, 32'h4,  1'b1);
        step(); expect_state("run2", 32'h8,  32'h4, 32'h4, 32'h8,  1'b1);
        step(); expect_state("run3", 32'hC,  32'h8, 32'h8, 32'hC,  1'b1);
        step(); expect_state("run4", 32'h10, 32'hC, 32'hC, 32'h10, 1'b1);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state($sformatf("stall%0d", i), 32'h10, 32'hC, 32'hC, 32'h10, 1'b1);
        end
        stall = 1'b0;
        step(); expect_state("stall_resume1", 32'h14, 32'h10, 32'h10, 32'h14, 1'b1);
        step(); expect_state("stall_resume2", 32'h18, 32'h14, 32'h14, 32'h18, 1'b1);
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
`ifdef IF_TRACE_EN
        expect_state("redir_bubble", 32'h40, NOP, 32'h0, 32'h0, 1'b0);
`else
        expect_state("redir_bubble", 32'h40, NOP, 32'h14, 32'h18, 1'b0);
`endif
        step(); expect_state("redir_target", 32'h44, 32'h40, 32'h40, 32'h44, 1'b1);
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0; stall = 1'b0;
`ifdef IF_TRACE_EN
        expect_state("rs_bubble", 32'h80, NOP, 32'h0, 32'h0, 1'b0);
`else
        expect_state("rs_bubble", 32'h80, NOP, 32'h40, 32'h44, 1'b0);
`endif
        step(); expect_state("rs_target", 32'h84, 32'h80, 32'h80, 32'h84, 1'b1);
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        total++;
        if (irom_addr !== 32'h100) begin
            bad++; $display("FAIL misalign irom_addr got=%h exp=%h", irom_addr, 32'h100);
        end
        step(); expect_state("misalign_target", 32'h104, 32'h100, 32'h100, 32'h104, 1'b1);
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        total++;
        if (irom_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_top irom_addr got=%h exp=%h", irom_addr, 32'hFFFF_FFFC);
        end
        step(); expect_state("wrap0", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
        step(); expect_state("wrap1", 32'h4, 32'h0, 32'h0, 32'h4, 1'b1);
        step(); expect_state("wrap2", 32'h8, 32'h4, 32'h4, 32'h8, 1'b1);
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        step(); expect_state("pre_rst_stall", 32'h8, 32'h4, 32'h4, 32'h8, 1'b1);
        #3 rst = 1'b1;
        #1 expect_state("async_rst", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b0; stall = 1'b0;
        step(); expect_state("post_rst1", 32'h4, 32'h0, 32'h0, 32'h4, 1'b1);
        step(); expect_state("post_rst2", 32'h8, 32'h4, 32'h4, 32'h8, 1'b1);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage miniRV pipeline. Holds the program counter and addresses the instruction ROM. Registers each fetched instruction with its PC and PC+4 for the decode stage, whose outputs feed the ID/EX register. Also applies load-use stalls from the hazard unit and branch/jump redirects resolved in EX.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `NOP_INST`, default `32'h0000_0013`: instruction (`addi x0,x0,0`) placed in IF/ID on flush or reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: hazard-unit load-use stall; freezes PC and IF/ID.
- `redirect` in 1: EX resolved a taken branch or jump this cycle.
- `redirect_pc` in 32: target address for `redirect`.
- `irom_addr` out 32: current PC, driven combinationally to the instruction ROM.
- `irom_inst` in 32: ROM data for `irom_addr`, valid in the same cycle.
- `inst_o` out 32: IF/ID instruction.
- `pc_o` out 32: IF/ID PC.
- `pc4_o` out 32: IF/ID PC+4.
- `have_inst_o` out 1: IF/ID slot holds a real instruction. Present only with `IF_TRACE_EN`.

## Operation
- PC register:
  - Reset: `RESET_PC`.
  - Each cycle the next PC is chosen by priority: `redirect` → `{redirect_pc[31:2],2'b00}`; else `stall` → hold; else `pc + 4`.
  - 32-bit unsigned add; `32'hFFFF_FFFC + 4` wraps to `0`.
- `irom_addr = pc`, with no registering.
- IF/ID register, updated by the same priority:
  - `redirect`: flush. `inst_o←NOP_INST`, `pc_o←0`, `pc4_o←0`, `have_inst_o←0`.
  - `stall`: hold all fields.
  - Otherwise: `inst_o←irom_inst`, `pc_o←pc`, `pc4_o←pc+4`, `have_inst_o←1`.
- `redirect` and `stall` asserted together: redirect wins, because the stalled instruction sits on the wrong path. PC loads the target and IF/ID is flushed.
- Misaligned `redirect_pc`: bits [1:0] are silently cleared. No exception is raised.
- Flushing the ID/EX register on a redirect is the ID/EX register's job, not this block's.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, so `irom_addr` = `RESET_PC`.
  - `inst_o` = `NOP_INST`; `pc_o` = 0; `pc4_o` = 0; `have_inst_o` = 0.
- Fetch latency: the instruction at PC `p`, sampled at edge N, appears on `inst_o` after edge N. The ID stage sees it one cycle after fetch.
- After reset deassertion, the first real instruction appears on the outputs after the first rising edge.
- Redirect asserted in cycle N:
  - After edge N, `irom_addr` equals the target and IF/ID holds a bubble.
  - After edge N+1, the target instruction is in IF/ID.
  - Taken-branch penalty is therefore 2 cycles. The ID/EX bubble is accounted for externally.
- Stall held for k cycles: PC and IF/ID stay constant for k edges, then resume with no instruction lost or duplicated.
- Reset mid-stall or mid-redirect: asynchronous reset overrides everything immediately.

## Configuration
- `IF_TRACE_EN` defined:
  - Port `have_inst_o` exists and behaves as above.
  - `pc_o` is cleared on flush as specified.
  - Used by the trace/difftest harness.
- `IF_TRACE_EN` undefined:
  - `have_inst_o` and its register are removed.
  - On flush, `pc_o` and `pc4_o` are left unchanged (not cleared); only `inst_o` becomes `NOP_INST`.
- Functional instruction flow is identical in both builds.

## Structure
- Shared package `pipe_pkg`: `RESET_PC` and `NOP_INST` defaults, the `XLEN=32` constant, and the PC increment constant `4`.
- One sub-module, `reg_if_id`: the IF/ID register with `stall`/`flush` inputs.
- `if_stage` instantiates `reg_if_id` and contains the PC register and next-PC mux.

## Test plan
- Reset then free-run with ROM word = address: `irom_addr` reads `0, 4, 8, C`; `inst_o`/`pc_o` lag by one cycle; `pc4_o = pc_o + 4`; `have_inst_o` goes 0→1 after the first edge.
- `stall` high for 3 cycles at PC `0x10`:
  - `irom_addr` holds `0x10` and `inst_o` holds the `0x0C` instruction for 3 cycles.
  - Then the sequence continues with `0x10`, with no skip or duplicate.
- `redirect=1`, `redirect_pc=0x40` at PC `0x18`:
  - Next cycle: `irom_addr=0x40`, `inst_o=0x00000013`, `have_inst_o=0`.
  - The following cycle: `pc_o=0x40`.
- `redirect` and `stall` together, target `0x80`:
  - PC becomes `0x80`; IF/ID is flushed (`inst_o=NOP`), not held.
- `redirect_pc=0x0000_0103`: PC becomes `0x100`. Separately, PC `0xFFFF_FFFC` free-running wraps to `0x0000_0000`.
- Assert `rst` asynchronously mid-cycle during a stall:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - Fetch restarts at `RESET_PC` after release.
